if_id_buffer: RTL
=================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered fetch entries (fixed 2 in this design).
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800, bubble instruction presented to decode.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Instr  input  16  instruction word from fetch.
REQ-006 SHALL have port pc_2_w  input  16  PC+2 accompanying Instr.
REQ-007 SHALL have port fetch_stall  input  1  fetch output invalid this cycle (cache miss or post-reset).
REQ-008 SHALL have port flush  input  1  branch taken or jump resolved; discard younger instructions.
REQ-009 SHALL have port id_stall  input  1  decode hazard; head entry must be held.
REQ-010 SHALL have port pc_hold  output  1  fetch must not advance PC.
REQ-011 SHALL have port ID_instr  output  16  instruction presented to decode.
REQ-012 SHALL have port ID_pc_2_w  output  16  PC+2 of ID_instr.
REQ-013 SHALL have port ID_valid  output  1  ID_instr is a real instruction.
REQ-014 SHALL have port ID_halt  output  1  valid head instruction has opcode Instr[15:11]==5'b00000.
REQ-015 SHALL have port bubble_cnt  output  16  decode bubble count (see Configuration).

Function
REQ-016 SHALL hold up to 2 {Instr, pc_2_w} entries in FIFO order with a 2-bit occupancy count (0..2).
REQ-017 SHALL enqueue when fetch_stall=0, flush=0, count<2 and halt_seen=0.
REQ-018 SHALL dequeue the head when count>0, id_stall=0 and flush=0.
REQ-019 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and shift the new entry behind the remaining one.
REQ-020 SHALL drive pc_hold = (count==2) | halt_seen, from registered state only.
REQ-021 SHALL present the head entry combinationally from registers: ID_valid=(count>0); ID_instr/ID_pc_2_w = head when valid, else NOP_INSTR/16'h0000.
REQ-022 SHALL, on flush, clear count to 0 and halt_seen to 0 next cycle; flush overrides enqueue, dequeue and id_stall.
REQ-023 SHALL set halt_seen when a halt opcode is enqueued; further enqueues are blocked until flush or rst.
REQ-024 SHALL assert ID_halt only when ID_valid=1 and ID_instr[15:11]==5'b00000.
REQ-025 SHALL ignore Instr contents whenever fetch_stall=1 (no enqueue, no halt detection).
REQ-026 SHALL add zero latency when empty-path: an instruction enqueued in cycle N is on ID_instr in cycle N+1.

Reset
REQ-027 SHALL on rst clear count, halt_seen and bubble_cnt; next cycle ID_valid=0, ID_instr=NOP_INSTR, ID_pc_2_w=0, ID_halt=0, pc_hold=0.
REQ-028 SHALL, for rst asserted mid-operation, discard all entries regardless of flush, id_stall or fetch_stall.

Configuration
REQ-029 SHALL, with IFID_BUBBLE_CNT_EN defined, count cycles with ID_valid=0 and rst=0 in a 16-bit counter saturating at 16'hFFFF; flush does not clear it.
REQ-030 SHALL, without IFID_BUBBLE_CNT_EN, drive bubble_cnt to 16'h0000 and instantiate no counter.

Structure
REQ-031 SHALL place NOP_INSTR value, HALT opcode 5'b00000 and depth constant in the shared pipeline package.
REQ-032 SHALL build each entry as sub-module ifid_slot: 32-bit enabled register with synchronous reset, built from dff.
REQ-033 SHALL contain no combinational path from Instr or fetch_stall to pc_hold.

Verification
REQ-034 SHALL verify: rst 1 cycle, then Instr=16'h4001,pc_2_w=16'h0002, fetch_stall=0 -> next cycle ID_valid=1, ID_instr=16'h4001, count=1.
REQ-035 SHALL verify: id_stall=1 for 3 cycles while fetch supplies 16'h4001,16'h4002 -> count=2, pc_hold=1, ID_instr stays 16'h4001; release -> 16'h4002 follows in order.
REQ-036 SHALL verify: count=2 and flush=1 with id_stall=1 -> next cycle ID_valid=0, ID_instr=16'h0800, pc_hold=0.
REQ-037 SHALL verify: fetch_stall=1 with Instr=16'h0000 -> no enqueue, ID_halt=0; then Instr=16'h0000 with fetch_stall=0 -> ID_halt=1, pc_hold=1 until flush.
REQ-038 SHALL verify: with IFID_BUBBLE_CNT_EN, 5 cycles fetch_stall=1 after reset -> bubble_cnt=5; without macro bubble_cnt=0.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline constants and the fetch-entry record for the IF/ID buffer.
package if_id_buffer_pkg;

    localparam int          IFID_DEPTH     = 2;
    localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;
    localparam logic [4:0]  IFID_HALT_OP   = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_2_w;
    } ifid_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == IFID_HALT_OP;
    endfunction

endpackage

// File: rtl/if_id_buffer_slot.sv
// Storage primitives for the IF/ID buffer: a generic enabled flop (dff) and
// the 32-bit entry register ifid_slot built from it.
module dff #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

module ifid_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    dff #(.W(32)) u_dff (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q)
    );

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID decoupling buffer with halt blocking and flush.
// Optional decode bubble counter enabled by defining IFID_BUBBLE_CNT_EN.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int          DEPTH     = IFID_DEPTH,
    parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [15:0] pc_2_w,
    input  logic        fetch_stall,
    input  logic        flush,
    input  logic        id_stall,
    output logic        pc_hold,
    output logic [15:0] ID_instr,
    output logic [15:0] ID_pc_2_w,
    output logic        ID_valid,
    output logic        ID_halt,
    output logic [15:0] bubble_cnt
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]  r_count;
    logic        r_halt_seen;
    ifid_entry_t w_head, w_tail, w_new, w_d0;
    logic        w_enq, w_deq, w_wr0, w_wr1;

    assign w_new = '{instr: Instr, pc_2_w: pc_2_w};
    assign w_enq = !fetch_stall && !flush && (r_count != FULL) && !r_halt_seen;
    assign w_deq = (r_count != 2'd0) && !id_stall && !flush;

    // Head is refilled from the tail when full, otherwise straight from fetch.
    assign w_wr0 = (w_deq && r_count == 2'd2)
                 || (w_enq && (r_count == 2'd0 || (r_count == 2'd1 && w_deq)));
    assign w_d0  = (w_deq && r_count == 2'd2) ? w_tail : w_new;
    assign w_wr1 = w_enq && (r_count == 2'd1) && !w_deq;

    ifid_slot u_slot0 (.clk(clk), .rst(rst), .en(w_wr0), .d(w_d0),  .q(w_head));
    ifid_slot u_slot1 (.clk(clk), .rst(rst), .en(w_wr1), .d(w_new), .q(w_tail));

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_count <= 2'd0;
        else if (w_enq && !w_deq)
            r_count <= r_count + 2'd1;
        else if (!w_enq && w_deq)
            r_count <= r_count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_halt_seen <= 1'b0;
        else if (w_enq && is_halt(Instr))
            r_halt_seen <= 1'b1;
    end

    assign pc_hold   = (r_count == FULL) || r_halt_seen;
    assign ID_valid  = (r_count != 2'd0);
    assign ID_instr  = ID_valid ? w_head.instr  : NOP_INSTR;
    assign ID_pc_2_w = ID_valid ? w_head.pc_2_w : 16'h0000;
    assign ID_halt   = ID_valid && is_halt(w_head.instr);

`ifdef IFID_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_bubble_cnt <= 16'h0000;
        else if (!ID_valid && r_bubble_cnt != 16'hFFFF)
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule
